// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared widths, limits and read-owner encoding for the dmem arbiter
package dmem_arbiter_pkg;

    localparam int AW_DEF           = 12;
    localparam int DW_DEF           = 32;
    localparam int STARVE_LIMIT_DEF = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_P0   = 2'b01,
        OWN_P1   = 2'b10
    } owner_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester ports and RAM side of the dmem arbiter
interface dmem_arbiter_if
    import dmem_arbiter_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) ();

    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          gnt0;
    logic          stall0;
    logic          rvalid0;
    logic [DW-1:0] rdata0;

    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          gnt1;
    logic          rvalid1;
    logic [DW-1:0] rdata1;

    logic          ram_wEn;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dataIn;
    logic [DW-1:0] ram_dataOut;

    modport slave (
        input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, ram_dataOut,
        output gnt0, stall0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
        output ram_wEn, ram_addr, ram_dataIn
    );

    modport master (
        output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, ram_dataOut,
        input  gnt0, stall0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
        input  ram_wEn, ram_addr, ram_dataIn
    );

endinterface

// File: rtl/dmem_arbiter_grant.sv
// rtl/dmem_arbiter_grant.sv - two-way grant with port 1 starvation guard or alternation
module arb2_grant
    import dmem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int RR_MODE      = 0
) (
    input  logic clock,
    input  logic reset,
    input  logic i_req0,
    input  logic i_req1,
    output logic o_gnt0,
    output logic o_gnt1
);

    localparam int            CW       = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT    = CW'(STARVE_LIMIT);
    localparam logic [CW-1:0] LIMIT_M1 = CW'(STARVE_LIMIT - 1);

    logic [CW-1:0] r_starve_cnt;
    logic          r_last_winner;
    logic          w_pick1;
    logic          w_gnt0;
    logic          w_gnt1;

    // w_pick1 only matters under contention; a lone requester always wins
    always_comb begin
        w_gnt0  = 1'b0;
        w_gnt1  = 1'b0;
        w_pick1 = (RR_MODE != 0) ? ~r_last_winner : (r_starve_cnt >= LIMIT_M1);
        if (reset) begin
            if (i_req0 && i_req1) begin
                w_gnt1 = w_pick1;
                w_gnt0 = ~w_pick1;
            end else begin
                w_gnt0 = i_req0;
                w_gnt1 = i_req1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_starve_cnt  <= '0;
            r_last_winner <= 1'b1;
        end else begin
            if (i_req1 && !w_gnt1)
                r_starve_cnt <= (r_starve_cnt == LIMIT) ? r_starve_cnt : r_starve_cnt + CW'(1);
            else
                r_starve_cnt <= '0;
            if (w_gnt0)
                r_last_winner <= 1'b0;
            else if (w_gnt1)
                r_last_winner <= 1'b1;
        end
    end

    assign o_gnt0 = w_gnt0;
    assign o_gnt1 = w_gnt1;

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the single-port data RAM between the processor and an aux master
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW           = AW_DEF,
    parameter int DW           = DW_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int RR_MODE      = 0
) (
    input  logic          clock,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);

    logic          w_gnt0;
    logic          w_gnt1;
    logic [AW-1:0] w_ram_addr;
    owner_e        w_rd_owner_nxt;
    owner_e        r_rd_owner;
    logic [AW-1:0] r_addr_hold;

    arb2_grant #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .RR_MODE      (RR_MODE)
    ) u_grant (
        .clock  (clock),
        .reset  (reset),
        .i_req0 (bus.req0),
        .i_req1 (bus.req1),
        .o_gnt0 (w_gnt0),
        .o_gnt1 (w_gnt1)
    );

    // the RAM address is parked on the last granted address while idle
    always_comb begin
        w_ram_addr     = r_addr_hold;
        w_rd_owner_nxt = OWN_NONE;
        if (w_gnt0) begin
            w_ram_addr = bus.addr0;
            if (!bus.we0) w_rd_owner_nxt = OWN_P0;
        end else if (w_gnt1) begin
            w_ram_addr = bus.addr1;
            if (!bus.we1) w_rd_owner_nxt = OWN_P1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_owner  <= OWN_NONE;
            r_addr_hold <= '0;
        end else begin
            r_rd_owner <= w_rd_owner_nxt;
            if (w_gnt0 || w_gnt1)
                r_addr_hold <= w_ram_addr;
        end
    end

    assign bus.gnt0       = w_gnt0;
    assign bus.gnt1       = w_gnt1;
    assign bus.stall0     = bus.req0 & ~w_gnt0;
    assign bus.ram_addr   = w_ram_addr;
    assign bus.ram_wEn    = (w_gnt0 & bus.we0) | (w_gnt1 & bus.we1);
    assign bus.ram_dataIn = w_gnt1 ? bus.wdata1 : bus.wdata0;
    assign bus.rvalid0    = (r_rd_owner == OWN_P0);
    assign bus.rvalid1    = (r_rd_owner == OWN_P1);
    assign bus.rdata0     = bus.ram_dataOut;
    assign bus.rdata1     = bus.ram_dataOut;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - bench for dmem_arbiter in both arbitration modes
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int LIM = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    dmem_arbiter_if #(.AW(AW), .DW(DW)) b0 ();
    dmem_arbiter_if #(.AW(AW), .DW(DW)) b1 ();

    dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM), .RR_MODE(0)) u_dut0 (
        .clock (clock), .reset (reset), .bus (b0.slave));
    dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM), .RR_MODE(1)) u_dut1 (
        .clock (clock), .reset (reset), .bus (b1.slave));

    logic [DW-1:0] ram0 [0:4095];
    logic [DW-1:0] ram1 [0:4095];
    always @(posedge clock) begin
        if (b0.ram_wEn) ram0[b0.ram_addr] <= b0.ram_dataIn;
        b0.ram_dataOut <= ram0[b0.ram_addr];
        if (b1.ram_wEn) ram1[b1.ram_addr] <= b1.ram_dataIn;
        b1.ram_dataOut <= ram1[b1.ram_addr];
    end

    int checks = 0;
    int errors = 0;

    logic          s_req0, s_we0, s_req1, s_we1;
    logic [AW-1:0] s_addr0, s_addr1;
    logic [DW-1:0] s_wd0, s_wd1;

    int            m_cnt   [2];
    int            m_last  [2];
    int            m_own   [2];
    logic [DW-1:0] m_rdata [2];
    bit            m_known [2];
    logic [AW-1:0] m_hold  [2];
    logic [DW-1:0] ref_mem [2][4096];
    bit            ref_ok  [2][4096];

    typedef struct {
        bit rst; bit r0; bit w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
        bit r1; bit w1; logic [AW-1:0] a1; logic [DW-1:0] d1;
        bit e_g0; bit e_g1; bit e_rv0; bit e_rv1; logic [DW-1:0] e_rd; bit chk_addr;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(bit rst, bit r0, bit w0, int a0, logic [DW-1:0] d0,
                                bit r1, bit w1, int a1, logic [DW-1:0] d1,
                                bit g0, bit g1, bit rv0, bit rv1, logic [DW-1:0] rd, bit ca);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0[AW-1:0]; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1[AW-1:0]; v.d1 = d1;
        v.e_g0 = g0; v.e_g1 = g1; v.e_rv0 = rv0; v.e_rv1 = rv1; v.e_rd = rd; v.chk_addr = ca;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit r0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input bit r1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        s_req0 = r0; s_we0 = w0; s_addr0 = a0; s_wd0 = d0;
        s_req1 = r1; s_we1 = w1; s_addr1 = a1; s_wd1 = d1;
        b0.req0 = r0; b0.we0 = w0; b0.addr0 = a0; b0.wdata0 = d0;
        b0.req1 = r1; b0.we1 = w1; b0.addr1 = a1; b0.wdata1 = d1;
        b1.req0 = r0; b1.we0 = w0; b1.addr0 = a0; b1.wdata0 = d0;
        b1.req1 = r1; b1.we1 = w1; b1.addr1 = a1; b1.wdata1 = d1;
    endtask

    // Which port the rules say wins this cycle: -1 none, 0 or 1
    function automatic int winner(int m);
        if (reset == 1'b0) return -1;
        if (s_req0 && s_req1) begin
            if (m == 0) return (m_cnt[m] >= LIM - 1) ? 1 : 0;
            return (m_last[m] == 0) ? 1 : 0;
        end
        if (s_req0) return 0;
        if (s_req1) return 1;
        return -1;
    endfunction

    task automatic model_reset(int m);
        m_cnt[m] = 0; m_last[m] = 1; m_own[m] = 0; m_hold[m] = '0; m_known[m] = 1'b0;
    endtask

    task automatic check_mode(int m);
        logic g0, g1, st0, wen, rv0, rv1;
        logic [AW-1:0] addr;
        logic [DW-1:0] din, rd0, rd1;
        int  w;
        bit  e_wen;
        g0   = (m == 0) ? b0.gnt0 : b1.gnt0;
        g1   = (m == 0) ? b0.gnt1 : b1.gnt1;
        st0  = (m == 0) ? b0.stall0 : b1.stall0;
        wen  = (m == 0) ? b0.ram_wEn : b1.ram_wEn;
        rv0  = (m == 0) ? b0.rvalid0 : b1.rvalid0;
        rv1  = (m == 0) ? b0.rvalid1 : b1.rvalid1;
        addr = (m == 0) ? b0.ram_addr : b1.ram_addr;
        din  = (m == 0) ? b0.ram_dataIn : b1.ram_dataIn;
        rd0  = (m == 0) ? b0.rdata0 : b1.rdata0;
        rd1  = (m == 0) ? b0.rdata1 : b1.rdata1;
        w = winner(m);
        e_wen = (w == 0 && s_we0) || (w == 1 && s_we1);
        chk($sformatf("m%0d_gnt_stall_wen", m), {g0, g1, st0, wen},
            {w == 0, w == 1, s_req0 && (w != 0), e_wen});
        if (reset)
            chk($sformatf("m%0d_ram_addr", m), addr,
                (w == 0) ? s_addr0 : (w == 1) ? s_addr1 : m_hold[m]);
        if (e_wen)
            chk($sformatf("m%0d_ram_dataIn", m), din, (w == 0) ? s_wd0 : s_wd1);
        chk($sformatf("m%0d_rvalid", m), {rv0, rv1},
            {reset && m_own[m] == 1, reset && m_own[m] == 2});
        if (reset && m_own[m] != 0 && m_known[m])
            chk($sformatf("m%0d_rdata", m), (m_own[m] == 1) ? rd0 : rd1, m_rdata[m]);
    endtask

    task automatic update_mode(int m);
        int w;
        w = winner(m);
        if (!reset) begin
            model_reset(m);
            return;
        end
        m_own[m] = 0;
        if (w >= 0) begin
            logic [AW-1:0] a;
            a = (w == 0) ? s_addr0 : s_addr1;
            m_hold[m] = a;
            m_last[m] = w;
            if ((w == 0) ? s_we0 : s_we1) begin
                ref_mem[m][a] = (w == 0) ? s_wd0 : s_wd1;
                ref_ok[m][a]  = 1'b1;
            end else begin
                m_own[m]   = w + 1;
                m_rdata[m] = ref_mem[m][a];
                m_known[m] = ref_ok[m][a];
            end
        end
        if (s_req1 && w != 1) m_cnt[m] = (m_cnt[m] + 1 > LIM) ? LIM : m_cnt[m] + 1;
        else                  m_cnt[m] = 0;
    endtask

    task automatic mid_check();
        #4;
        check_mode(0);
        check_mode(1);
    endtask

    task automatic advance();
        @(posedge clock);
        #1;
        update_mode(0);
        update_mode(1);
    endtask

    initial begin
        model_reset(0);
        model_reset(1);
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        @(posedge clock);
        #1;

        tbl.push_back(mk(0, 1,0,'h010,0,          1,0,'h020,0,  0,0,0,0,0,0));
        tbl.push_back(mk(0, 1,0,'h010,0,          1,0,'h020,0,  0,0,0,0,0,0));
        tbl.push_back(mk(1, 1,1,'h010,'hDEADBEEF, 1,0,'h020,0,  1,0,0,0,0,0));
        tbl.push_back(mk(1, 1,0,'h010,0,          0,0,0,0,      1,0,0,0,0,0));
        tbl.push_back(mk(1, 0,0,0,0,              0,0,0,0,      0,0,1,0,'hDEADBEEF,0));
        tbl.push_back(mk(1, 0,0,0,0,              1,0,'h010,0,  0,1,0,0,0,0));
        tbl.push_back(mk(1, 0,0,0,0,              0,0,0,0,      0,0,0,1,'hDEADBEEF,0));
        tbl.push_back(mk(1, 1,1,'h020,'hCAFEF00D, 0,0,0,0,      1,0,0,0,0,0));
        tbl.push_back(mk(1, 0,0,0,0,              1,0,'h020,0,  0,1,0,0,0,0));
        tbl.push_back(mk(1, 0,0,0,0,              0,0,0,0,      0,0,0,1,'hCAFEF00D,0));
        tbl.push_back(mk(1, 1,1,'h001,'h11,       0,0,0,0,      1,0,0,0,0,0));
        tbl.push_back(mk(1, 0,0,0,0,              1,1,'h002,'h22, 0,1,0,0,0,0));
        tbl.push_back(mk(1, 1,1,'h3FF,'h12345678, 0,0,0,0,      1,0,0,0,0,1));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1, 0,0,0,0,          0,0,0,0,      0,0,0,0,0,1));

        foreach (tbl[i]) begin
            reset = tbl[i].rst;
            drive(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0, tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
            mid_check();
            chk($sformatf("tbl%0d_gnt", i), {b0.gnt0, b0.gnt1}, {tbl[i].e_g0, tbl[i].e_g1});
            chk($sformatf("tbl%0d_rvalid", i), {b0.rvalid0, b0.rvalid1}, {tbl[i].e_rv0, tbl[i].e_rv1});
            if (tbl[i].e_rv0) chk($sformatf("tbl%0d_rdata0", i), b0.rdata0, tbl[i].e_rd);
            if (tbl[i].e_rv1) chk($sformatf("tbl%0d_rdata1", i), b0.rdata1, tbl[i].e_rd);
            if (tbl[i].chk_addr)
                chk($sformatf("tbl%0d_hold", i), {b0.ram_addr, b0.ram_wEn}, {12'h3FF, tbl[i].w0});
            advance();
        end

        // contention from a clean reset
        reset = 1'b0;
        drive(1, 0, 12'h001, '0, 1, 0, 12'h002, '0);
        mid_check();
        advance();
        reset = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            mid_check();
            chk($sformatf("starve_k%0d", k), {b0.gnt0, b0.gnt1, b0.stall0},
                {k % 8 != 0, k % 8 == 0, k % 8 == 0});
            chk($sformatf("alt_k%0d", k), {b1.gnt0, b1.gnt1}, {k % 2 == 1, k % 2 == 0});
            if (k > 1) begin
                chk($sformatf("alt_rv_k%0d", k), {b1.rvalid0, b1.rvalid1}, {k % 2 == 0, k % 2 == 1});
                chk($sformatf("alt_rd_k%0d", k), (k % 2 == 0) ? b1.rdata0 : b1.rdata1,
                    (k % 2 == 0) ? 32'h11 : 32'h22);
            end
            advance();
        end

        // reset lands between a port 1 read grant and its return
        drive(0, 0, '0, '0, 1, 0, 12'h002, '0);
        mid_check();
        chk("midrst_granted", b0.gnt1, 1'b1);
        reset = 1'b0;
        #1;
        chk("midrst_forced", {b0.gnt1, b0.rvalid1, b1.gnt1, b1.rvalid1}, 4'b0000);
        advance();
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        mid_check();
        advance();
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            mid_check();
            chk($sformatf("midrst_after%0d", k), {b0.rvalid0, b0.rvalid1, b1.rvalid0, b1.rvalid1}, 4'b0000);
            advance();
        end

        for (int a = 0; a < 16; a++) begin
            drive(1, 1, AW'(a), DW'($urandom), 0, 0, '0, '0);
            mid_check();
            advance();
        end

        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 59) != 0);
            drive($urandom_range(0, 1), $urandom_range(0, 1), AW'($urandom_range(0, 15)), DW'($urandom),
                  $urandom_range(0, 1), $urandom_range(0, 1), AW'($urandom_range(0, 15)), DW'($urandom));
            mid_check();
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
